// File: rtl/neuron_synapse_pkg.sv
// Shared layout constants and helpers for the synapse/neuron core.
// Neuron words and 4-bit synapse nibbles are described as packed structs.
package neuron_synapse_pkg;

  localparam int SYN_DEPTH  = 8192;
  localparam int NEUR_DEPTH = 256;
  localparam int SYN_WIDTH  = 32;
  localparam int NEUR_WIDTH = 128;

  localparam int NIB_W   = 4;
  localparam int NIBS    = SYN_WIDTH / NIB_W;
  localparam int WGT_W   = 3;
  localparam int MAP_BIT = 3;

  localparam int DIS_BIT  = 0;
  localparam int THR_LSB  = 1;
  localparam int THR_W    = 8;
  localparam int LEAK_LSB = 9;
  localparam int LEAK_W   = 8;
  localparam int U_LSB    = 17;
  localparam int U_W      = 8;
  localparam int CORE_W   = U_LSB + U_W;

  // One synapse nibble: mapped flag above a 3-bit weight.
  typedef struct packed {
    logic             mapped;
    logic [WGT_W-1:0] w;
  } syn_nib_t;

  // Low 25 bits of a neuron word; everything above is carried through.
  typedef struct packed {
    logic [U_W-1:0]    u;
    logic [LEAK_W-1:0] leak;
    logic [THR_W-1:0]  thr;
    logic              dis;
  } neur_core_t;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_LEAK  = 2'd1,
    UPD_EVENT = 2'd2
  } upd_kind_t;

  function automatic logic [U_W-1:0] u_add(input logic [U_W-1:0] u, input logic [WGT_W-1:0] w);
    logic [U_W:0] s;
    s = {1'b0, u} + {{(U_W-WGT_W+1){1'b0}}, w};
    return s[U_W] ? {U_W{1'b1}} : s[U_W-1:0];
  endfunction

  function automatic logic [U_W-1:0] u_sub(input logic [U_W-1:0] u, input logic [U_W-1:0] d);
    return (u > d) ? (u - d) : '0;
  endfunction

  // Stop-learning step: potentiation wins over depression, weights clamp at 0..7.
  function automatic syn_nib_t learn_nib(input syn_nib_t n, input logic en,
                                         input logic up, input logic down);
    syn_nib_t r;
    r = n;
    if (en && up) begin
      if (n.w != 3'd7) r.w = n.w + 3'd1;
    end else if (en && down) begin
      if (n.w != 3'd0) r.w = n.w - 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_bytewrite.sv
// Single-port RAM with byte-masked write and a registered, reset-cleared read port.
// A write presented while reset is high is dropped; contents are never cleared.
module sram_bytewrite #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/8-1:0]       wmask,
  output logic [WIDTH-1:0]         rdata
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (cs && !we) begin
      rdata <= mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cs && we) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/neuron_synapse_core.sv
// Synapse array plus leaky integrate-and-fire neuron array with stop-learning
// write-back; byte-programmable while SPI_GATE_ACTIVITY_sync is high.
module neuron_synapse_core
  import neuron_synapse_pkg::*;
#(
  parameter int N = 256,
  parameter int M = 8
) (
  input  logic            CLK,
  input  logic            RSTN_syncn,
  input  logic            SPI_GATE_ACTIVITY_sync,
  input  logic [N-1:0]    SPI_SYN_SIGN,
  input  logic            SPI_UPDATE_UNMAPPED_SYN,
  input  logic            SPI_PROPAGATE_UNMAPPED_SYN,
  input  logic [7:0]      CTRL_PRE_EN,
  input  logic            CTRL_BIST_REF,
  input  logic            CTRL_SYNARRAY_CS,
  input  logic            CTRL_SYNARRAY_WE,
  input  logic [12:0]     CTRL_SYNARRAY_ADDR,
  input  logic            CTRL_NEURMEM_CS,
  input  logic            CTRL_NEURMEM_WE,
  input  logic [M-1:0]    CTRL_NEURMEM_ADDR,
  input  logic [2*M-1:0]  CTRL_PROG_DATA,
  input  logic [2*M-1:0]  CTRL_SPI_ADDR,
  input  logic            CTRL_NEUR_EVENT,
  input  logic            CTRL_NEUR_TREF,
  input  logic [4:0]      CTRL_NEUR_VIRTS,
  input  logic            CTRL_NEUR_BURST_END,
  output logic [31:0]     SYNARRAY_RDATA,
  output logic [31:0]     SYNARRAY_WDATA,
  output logic            SYN_SIGN,
  output logic [127:0]    NEUR_STATE,
  output logic [6:0]      NEUR_EVENT_OUT,
  output logic [N-1:0]    NEUR_V_UP,
  output logic [N-1:0]    NEUR_V_DOWN,
  output logic [14:0]     NEUR_STATE_MONITOR
);

  // Access protocol: the controller reads (CS=1, WE=0) on cycle t with
  // EVENT/TREF already asserted, then holds them on cycle t+1 with WE=1; the
  // write-back word is combinational from the registered read data and the
  // current controls, so nothing here stalls or back-pressures.

  logic                  gate;
  logic [SYN_WIDTH-1:0]  syn_wdata;
  logic [3:0]            syn_wmask;
  logic [NEUR_WIDTH-1:0] neur_wdata;
  logic [15:0]           neur_wmask;
  logic [NEUR_WIDTH-1:0] neur_next;

  assign gate     = SPI_GATE_ACTIVITY_sync;
  assign SYN_SIGN = SPI_SYN_SIGN[CTRL_SYNARRAY_ADDR[12:5]];

  always_comb begin
    syn_wdata  = SYNARRAY_WDATA;
    syn_wmask  = 4'hF;
    neur_wdata = neur_next;
    neur_wmask = 16'hFFFF;
    if (gate) begin
      syn_wdata  = {4{CTRL_PROG_DATA[7:0]}};
      syn_wmask  = 4'b0001 << CTRL_SPI_ADDR[14:13];
      neur_wdata = {16{CTRL_PROG_DATA[7:0]}};
      neur_wmask = 16'h0001 << CTRL_SPI_ADDR[11:8];
    end
  end

  sram_bytewrite #(.DEPTH(SYN_DEPTH), .WIDTH(SYN_WIDTH)) u_syn_mem (
    .clk   (CLK),
    .rst   (RSTN_syncn),
    .cs    (CTRL_SYNARRAY_CS),
    .we    (CTRL_SYNARRAY_WE),
    .addr  (CTRL_SYNARRAY_ADDR),
    .wdata (syn_wdata),
    .wmask (syn_wmask),
    .rdata (SYNARRAY_RDATA)
  );

  sram_bytewrite #(.DEPTH(NEUR_DEPTH), .WIDTH(NEUR_WIDTH)) u_neur_mem (
    .clk   (CLK),
    .rst   (RSTN_syncn),
    .cs    (CTRL_NEURMEM_CS),
    .we    (CTRL_NEURMEM_WE),
    .addr  (CTRL_NEURMEM_ADDR),
    .wdata (neur_wdata),
    .wmask (neur_wmask),
    .rdata (NEUR_STATE)
  );

  // Event operands: a virtual event overrides the stored nibble entirely.
  syn_nib_t         cur_nib;
  neur_core_t       core;
  logic             virt;
  logic [WGT_W-1:0] ev_w;
  logic             ev_mapped;
  logic             ev_sign;

  assign cur_nib   = SYNARRAY_RDATA[{CTRL_NEURMEM_ADDR[2:0], 2'b00} +: NIB_W];
  assign core      = NEUR_STATE[CORE_W-1:0];
  assign virt      = CTRL_NEUR_VIRTS[4];
  assign ev_w      = virt ? CTRL_NEUR_VIRTS[2:0] : cur_nib.w;
  assign ev_mapped = virt | cur_nib.mapped;
  assign ev_sign   = virt ? CTRL_NEUR_VIRTS[3] : SYN_SIGN;

  upd_kind_t      upd_kind;
  logic [U_W-1:0] u_upd;
  logic [U_W-1:0] u_next;
  logic           spike;
  logic           ev_applied;
  logic           v_up_next;
  logic           v_down_next;

  always_comb begin
    upd_kind = UPD_NONE;
    u_upd    = core.u;
    if (CTRL_NEUR_TREF && !core.dis) begin
      upd_kind = UPD_LEAK;
      u_upd    = u_sub(core.u, core.leak);
    end else if (CTRL_NEUR_EVENT && (ev_mapped || SPI_PROPAGATE_UNMAPPED_SYN) && !core.dis) begin
      upd_kind = UPD_EVENT;
      u_upd    = ev_sign ? u_sub(core.u, {5'b0, ev_w}) : u_add(core.u, ev_w);
    end
  end

  // A zero threshold means the neuron never fires.
  assign spike       = (upd_kind != UPD_NONE) && (core.thr != '0) && (u_upd >= core.thr);
  assign u_next      = spike ? '0 : u_upd;
  assign ev_applied  = (upd_kind == UPD_EVENT);
  assign neur_next   = {NEUR_STATE[NEUR_WIDTH-1:CORE_W], u_next, core.leak, core.thr, core.dis};
  assign v_up_next   = (u_next >= {1'b0, core.thr[THR_W-1:1]});
  assign v_down_next = !v_up_next && (u_next != '0);

  logic neur_wb;
  assign neur_wb = CTRL_NEURMEM_CS && CTRL_NEURMEM_WE && !gate;

  always_ff @(posedge CLK) begin
    if (RSTN_syncn) begin
      NEUR_EVENT_OUT     <= '0;
      NEUR_STATE_MONITOR <= '0;
      NEUR_V_UP          <= '0;
      NEUR_V_DOWN        <= '0;
    end else if (neur_wb) begin
      NEUR_EVENT_OUT     <= {spike, u_next[7:2]};
      NEUR_STATE_MONITOR <= {u_next, ev_sign, ev_w, ev_mapped, ev_applied, spike};
      NEUR_V_UP[CTRL_NEURMEM_ADDR]   <= v_up_next;
      NEUR_V_DOWN[CTRL_NEURMEM_ADDR] <= v_down_next;
    end
  end

  // Each nibble k of the addressed word targets post-neuron {ADDR[4:0], k}.
  for (genvar k = 0; k < NIBS; k++) begin : g_learn
    syn_nib_t       old_nib;
    logic [M-1:0]   post;
    logic           en;
    assign old_nib = SYNARRAY_RDATA[k*NIB_W +: NIB_W];
    assign post    = {CTRL_SYNARRAY_ADDR[4:0], 3'(k)};
    assign en      = CTRL_PRE_EN[k] && (old_nib.mapped || SPI_UPDATE_UNMAPPED_SYN);
    assign SYNARRAY_WDATA[k*NIB_W +: NIB_W] = learn_nib(old_nib, en, NEUR_V_UP[post], NEUR_V_DOWN[post]);
  end

  logic unused_inputs;
  assign unused_inputs = ^{CTRL_BIST_REF, CTRL_NEUR_BURST_END, CTRL_PROG_DATA[2*M-1:8],
                           CTRL_SPI_ADDR[15], CTRL_SPI_ADDR[12], CTRL_SPI_ADDR[7:0]};

endmodule

// File: tb/tb_neuron_synapse_core.sv
// Directed bench for neuron_synapse_core: programming, integrate/leak/spike,
// virtual and unmapped events, learning write-back and reset during a write.
module tb_neuron_synapse_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         gate;
  logic [255:0] syn_sign;
  logic         upd_unm;
  logic         prop_unm;
  logic [7:0]   pre_en;
  logic         bist;
  logic         syn_cs;
  logic         syn_we;
  logic [12:0]  syn_addr;
  logic         neur_cs;
  logic         neur_we;
  logic [7:0]   neur_addr;
  logic [15:0]  prog_data;
  logic [15:0]  spi_addr;
  logic         ev;
  logic         tref;
  logic [4:0]   virts;
  logic         burst_end;

  logic [31:0]  syn_rdata;
  logic [31:0]  syn_wdata;
  logic         syn_sign_o;
  logic [127:0] neur_state;
  logic [6:0]   event_out;
  logic [255:0] v_up;
  logic [255:0] v_down;
  logic [14:0]  monitor;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] NW8 = 128'hAFAEADACABAAA9A8A7A6A5A4_00060414;

  always #5 clk = ~clk;

  neuron_synapse_core dut (
    .CLK                        (clk),
    .RSTN_syncn                 (rst),
    .SPI_GATE_ACTIVITY_sync     (gate),
    .SPI_SYN_SIGN               (syn_sign),
    .SPI_UPDATE_UNMAPPED_SYN    (upd_unm),
    .SPI_PROPAGATE_UNMAPPED_SYN (prop_unm),
    .CTRL_PRE_EN                (pre_en),
    .CTRL_BIST_REF              (bist),
    .CTRL_SYNARRAY_CS           (syn_cs),
    .CTRL_SYNARRAY_WE           (syn_we),
    .CTRL_SYNARRAY_ADDR         (syn_addr),
    .CTRL_NEURMEM_CS            (neur_cs),
    .CTRL_NEURMEM_WE            (neur_we),
    .CTRL_NEURMEM_ADDR          (neur_addr),
    .CTRL_PROG_DATA             (prog_data),
    .CTRL_SPI_ADDR              (spi_addr),
    .CTRL_NEUR_EVENT            (ev),
    .CTRL_NEUR_TREF             (tref),
    .CTRL_NEUR_VIRTS            (virts),
    .CTRL_NEUR_BURST_END        (burst_end),
    .SYNARRAY_RDATA             (syn_rdata),
    .SYNARRAY_WDATA             (syn_wdata),
    .SYN_SIGN                   (syn_sign_o),
    .NEUR_STATE                 (neur_state),
    .NEUR_EVENT_OUT             (event_out),
    .NEUR_V_UP                  (v_up),
    .NEUR_V_DOWN                (v_down),
    .NEUR_STATE_MONITOR         (monitor)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Neuron word 8 layout with chosen low fields; upper bits keep the programmed pattern.
  function automatic logic [127:0] mk_neur(input logic [7:0] u, input logic [7:0] leak,
                                           input logic [7:0] thr, input logic dis);
    return {NW8[127:25], u, leak, thr, dis};
  endfunction

  task automatic idle();
    syn_cs = 1'b0; syn_we = 1'b0; neur_cs = 1'b0; neur_we = 1'b0; ev = 1'b0; tref = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic prog_syn_word(input logic [12:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      gate = 1'b1; syn_cs = 1'b1; syn_we = 1'b1; syn_addr = a;
      spi_addr = 16'(i) << 13; prog_data = {8'hEE, w[i*8 +: 8]};
      step();
      idle();
    end
  endtask

  task automatic prog_neur_word(input logic [7:0] a, input logic [127:0] w);
    for (int i = 0; i < 16; i++) begin
      gate = 1'b1; neur_cs = 1'b1; neur_we = 1'b1; neur_addr = a;
      spi_addr = 16'(i) << 8; prog_data = {8'hEE, w[i*8 +: 8]};
      step();
      idle();
    end
  endtask

  task automatic read_syn(input logic [12:0] a);
    syn_cs = 1'b1; syn_we = 1'b0; syn_addr = a;
    step();
    idle();
  endtask

  task automatic read_neur(input logic [7:0] a);
    neur_cs = 1'b1; neur_we = 1'b0; neur_addr = a;
    step();
    idle();
  endtask

  // Read cycle then write-back cycle with EVENT or TREF held across both.
  task automatic do_update(input logic [7:0] na, input logic [12:0] sa, input logic is_tref);
    gate = 1'b0; neur_addr = na; syn_addr = sa;
    syn_cs = 1'b1; syn_we = 1'b0; neur_cs = 1'b1; neur_we = 1'b0;
    ev = !is_tref; tref = is_tref;
    step();
    neur_we = 1'b1;
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1; gate = 1'b1; syn_sign = '0; upd_unm = 1'b0; prop_unm = 1'b0; pre_en = 8'h00;
    bist = 1'b0; syn_addr = '0; neur_addr = '0; prog_data = '0; spi_addr = '0; virts = '0;
    burst_end = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check("rst_rdata", syn_rdata, 0);
    check("rst_nstate", neur_state, 0);
    check("rst_evout", event_out, 0);
    check("rst_mon", monitor, 0);
    check("rst_vup", v_up, 0);
    check("rst_vdown", v_down, 0);
    rst = 1'b0;

    prog_syn_word(13'd5, 32'h12345678);
    read_syn(13'd5);
    check("prog_syn", syn_rdata, 32'h12345678);
    gate = 1'b1; syn_cs = 1'b1; syn_we = 1'b1; syn_addr = 13'd5;
    spi_addr = 16'h2000; prog_data = 16'h55AB;
    step();
    idle();
    read_syn(13'd5);
    check("prog_syn_lane1", syn_rdata, 32'h1234AB78);
    prog_neur_word(8'd8, NW8);
    read_neur(8'd8);
    check("prog_neur", neur_state, NW8);

    prog_syn_word(13'h41, 32'h0000000D);
    do_update(8'd8, 13'h41, 1'b0);
    check("exc_evout", event_out, 7'h02);
    check("exc_mon", monitor, 15'h042E);
    check("exc_vup", v_up[8], 1'b1);
    check("exc_vdown", v_down[8], 1'b0);
    read_neur(8'd8);
    check("exc_u", neur_state, mk_neur(8'd8, 8'd2, 8'd10, 1'b0));

    do_update(8'd8, 13'h41, 1'b0);
    check("spike_evout", event_out, 7'h40);
    check("spike_vup", v_up[8], 1'b0);
    read_neur(8'd8);
    check("spike_u", neur_state, mk_neur(8'd0, 8'd2, 8'd10, 1'b0));

    prog_neur_word(8'd8, NW8);
    check("prog_no_update", event_out, 7'h40);
    syn_sign[2] = 1'b1;
    syn_addr = 13'h41;
    #1;
    check("syn_sign", syn_sign_o, 1'b1);
    do_update(8'd8, 13'h41, 1'b0);
    check("inh_evout", event_out, 7'h00);
    check("inh_mon", monitor, 15'h006E);
    read_neur(8'd8);
    check("inh_u", neur_state, mk_neur(8'd0, 8'd2, 8'd10, 1'b0));
    syn_sign[2] = 1'b0;

    prog_neur_word(8'd8, mk_neur(8'd7, 8'd2, 8'd10, 1'b0));
    do_update(8'd8, 13'h41, 1'b1);
    check("leak_evout", event_out, 7'h01);
    check("leak_mon", monitor, 15'h02AC);
    check("leak_vup", v_up[8], 1'b1);
    read_neur(8'd8);
    check("leak_u", neur_state, mk_neur(8'd5, 8'd2, 8'd10, 1'b0));

    prog_syn_word(13'h41, 32'h00000005);
    prog_neur_word(8'd8, mk_neur(8'd9, 8'd2, 8'd10, 1'b0));
    do_update(8'd8, 13'h41, 1'b0);
    check("unm_evout", event_out, 7'h02);
    check("unm_mon", monitor, 15'h04A8);
    read_neur(8'd8);
    check("unm_u", neur_state, mk_neur(8'd9, 8'd2, 8'd10, 1'b0));
    prop_unm = 1'b1;
    do_update(8'd8, 13'h41, 1'b0);
    check("prop_evout", event_out, 7'h40);
    read_neur(8'd8);
    check("prop_u", neur_state, mk_neur(8'd0, 8'd2, 8'd10, 1'b0));
    prop_unm = 1'b0;

    virts = 5'b10011;
    do_update(8'd8, 13'h41, 1'b0);
    check("virt_evout", event_out, 7'h00);
    check("virt_mon", monitor, 15'h019E);
    read_neur(8'd8);
    check("virt_u", neur_state, mk_neur(8'd3, 8'd2, 8'd10, 1'b0));
    virts = 5'b00000;

    prog_syn_word(13'h41, 32'h0000000D);
    prog_neur_word(8'd8, mk_neur(8'd254, 8'd2, 8'd0, 1'b0));
    do_update(8'd8, 13'h41, 1'b0);
    check("sat_evout", event_out, 7'h3F);
    read_neur(8'd8);
    check("sat_u", neur_state, mk_neur(8'd255, 8'd2, 8'd0, 1'b0));

    prog_neur_word(8'd8, mk_neur(8'd4, 8'd2, 8'd10, 1'b1));
    do_update(8'd8, 13'h41, 1'b0);
    check("dis_evout", event_out, 7'h01);
    read_neur(8'd8);
    check("dis_u", neur_state, mk_neur(8'd4, 8'd2, 8'd10, 1'b1));

    prog_neur_word(8'd8,  mk_neur(8'd6, 8'd0, 8'd10, 1'b0));
    prog_neur_word(8'd9,  mk_neur(8'd2, 8'd0, 8'd10, 1'b0));
    prog_neur_word(8'd11, mk_neur(8'd6, 8'd0, 8'd10, 1'b0));
    prog_neur_word(8'd12, mk_neur(8'd2, 8'd0, 8'd10, 1'b0));
    do_update(8'd8,  13'h41, 1'b1);
    do_update(8'd9,  13'h41, 1'b1);
    do_update(8'd11, 13'h41, 1'b1);
    do_update(8'd12, 13'h41, 1'b1);
    check("learn_vup8", v_up[8], 1'b1);
    check("learn_vdown9", v_down[9], 1'b1);
    check("learn_vup11", v_up[11], 1'b1);
    check("learn_vdown12", v_down[12], 1'b1);
    check("learn_flags10", {v_up[10], v_down[10]}, 2'b00);

    prog_syn_word(13'h41, 32'h000CAB8F);
    pre_en = 8'h1F;
    read_syn(13'h41);
    check("learn_rdata", syn_rdata, 32'h000CAB8F);
    check("learn_wdata", syn_wdata, 32'h000BBB8F);
    pre_en = 8'h00;
    #1;
    check("learn_preen0", syn_wdata, 32'h000CAB8F);
    pre_en = 8'h1F;
    gate = 1'b0; syn_cs = 1'b1; syn_we = 1'b1; syn_addr = 13'h41;
    step();
    idle();
    read_syn(13'h41);
    check("learn_wb", syn_rdata, 32'h000BBB8F);

    gate = 1'b0; neur_addr = 8'd8; syn_addr = 13'h41;
    syn_cs = 1'b1; syn_we = 1'b0; neur_cs = 1'b1; neur_we = 1'b0; ev = 1'b1;
    step();
    syn_we = 1'b1; neur_we = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("rstw_rdata", syn_rdata, 0);
    check("rstw_nstate", neur_state, 0);
    check("rstw_evout", event_out, 0);
    check("rstw_mon", monitor, 0);
    check("rstw_vup", v_up, 0);
    check("rstw_vdown", v_down, 0);
    read_neur(8'd8);
    check("rstw_neur_kept", neur_state, mk_neur(8'd6, 8'd0, 8'd10, 1'b0));
    read_syn(13'h41);
    check("rstw_syn_kept", syn_rdata, 32'h000BBB8F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
